// File: rtl/aes_uart_pkg.sv
// Shared constants and state encoding for the UART-to-AES framing path.
// Imported by the frame assembler and any future byte-stream framer.
package aes_uart_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int FRAME_BYTES     = 32;
  localparam int UART_CHAR_BITS  = 10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT_KEY = 2'd1,
    COLLECT_PT  = 2'd2,
    VALID       = 2'd3
  } asm_state_t;

  // Idle gap, in clocks, that aborts a partially received frame.
  function automatic int gap_timeout_clks(input int clk_freq, input int baudrate,
                                          input int timeout_bytes);
    return timeout_bytes * UART_CHAR_BITS * (clk_freq / baudrate);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and
// pulses expired for one cycle when the gap reaches TIMEOUT_CLKS.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 34720
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CLKS + 1);

  logic [W-1:0] r_count;

  // Fires on the cycle whose edge would take the count to TIMEOUT_CLKS.
  assign expired = enable && (r_count == W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || !enable || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_frame_assembler.sv
// Packs 32 UART bytes into a 128-bit key plus 128-bit plaintext and offers
// them over valid/ready; aborts partial frames after an idle gap.
module aes_frame_assembler
  import aes_uart_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUDRATE      = 115_200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                data_in,
  input  logic                      data_in_done,
  output logic [AES_BLOCK_BITS-1:0] key_out,
  output logic [AES_BLOCK_BITS-1:0] plaintext_out,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      overflow_err
);

  localparam int         TIMEOUT_CLKS = gap_timeout_clks(CLK_FREQ, BAUDRATE, TIMEOUT_BYTES);
  localparam logic [4:0] LAST_KEY_IDX = 5'(AES_BLOCK_BYTES - 1);
  localparam logic [4:0] LAST_IDX     = 5'(FRAME_BYTES - 1);

  asm_state_t                r_state;
  logic [4:0]                r_count;
  logic [AES_BLOCK_BITS-1:0] r_key;
  logic [AES_BLOCK_BITS-1:0] r_pt;
  logic                      r_block_valid;
  logic                      r_busy;
  logic                      r_timeout_err;
  logic                      r_overflow_err;

  logic w_collecting;
  logic w_expired;

  assign w_collecting = (r_state == COLLECT_KEY) || (r_state == COLLECT_PT);

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (data_in_done),
    .enable (w_collecting),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_key          <= '0;
      r_pt           <= '0;
      r_block_valid  <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_timeout_err  <= 1'b0;
      r_overflow_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_in_done) begin
            r_key   <= {r_key[AES_BLOCK_BITS-9:0], data_in};
            r_count <= 5'd1;
            r_state <= COLLECT_KEY;
            r_busy  <= 1'b1;
          end
        end
        COLLECT_KEY, COLLECT_PT: begin
          if (w_expired) begin
            // A byte landing on the expiry cycle starts the next frame.
            r_timeout_err <= 1'b1;
            if (data_in_done) begin
              r_key   <= {r_key[AES_BLOCK_BITS-9:0], data_in};
              r_count <= 5'd1;
              r_state <= COLLECT_KEY;
            end else begin
              r_count <= '0;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (data_in_done) begin
            if (r_state == COLLECT_KEY) begin
              r_key <= {r_key[AES_BLOCK_BITS-9:0], data_in};
              if (r_count == LAST_KEY_IDX) r_state <= COLLECT_PT;
              r_count <= r_count + 5'd1;
            end else begin
              r_pt <= {r_pt[AES_BLOCK_BITS-9:0], data_in};
              if (r_count == LAST_IDX) begin
                r_count       <= '0;
                r_state       <= VALID;
                r_block_valid <= 1'b1;
                r_busy        <= 1'b0;
              end else begin
                r_count <= r_count + 5'd1;
              end
            end
          end
        end
        VALID: begin
          if (block_ready) begin
            r_block_valid <= 1'b0;
            if (data_in_done) begin
              r_key   <= {r_key[AES_BLOCK_BITS-9:0], data_in};
              r_count <= 5'd1;
              r_state <= COLLECT_KEY;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (data_in_done) begin
            r_overflow_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_out       = r_key;
  assign plaintext_out = r_pt;
  assign block_valid   = r_block_valid;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;
  assign overflow_err  = r_overflow_err;

endmodule

// File: tb/tb_aes_frame_assembler.sv
// Randomised self-checking bench for aes_frame_assembler; expected frames are
// packed from a byte array, independent of the DUT's shift logic.
module tb_aes_frame_assembler;

  localparam int TIMEOUT_CLKS = 34720;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_in_done = 1'b0;
  logic [127:0] key_out;
  logic [127:0] plaintext_out;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic         busy;
  logic         timeout_err;
  logic         overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fb [32];

  always #5 clk = ~clk;

  aes_frame_assembler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_done (data_in_done),
    .key_out      (key_out),
    .plaintext_out(plaintext_out),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte fb[base] lands in the top byte of the 128-bit word.
  function automatic logic [127:0] pack_half(input int base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fb[base+i];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in      = b;
    data_in_done = 1'b1;
    @(negedge clk);
    data_in_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends fb[first..31] with random gaps; checks busy during collection and
  // the assembled frame one cycle after the last byte.
  task automatic send_frame(input string name, input int first, input int gmin, input int gmax);
    for (int i = first; i < 32; i++) begin
      if (i != first) idle(int'($urandom_range(gmax, gmin)));
      send_byte(fb[i]);
      if (i < 31) begin
        if (i == first || i == 15 || i == 30) begin
          check_eq({name, "_busy"}, 128'(busy), 128'(1));
          check_eq({name, "_novalid"}, 128'(block_valid), 128'(0));
        end
      end
    end
    check_eq({name, "_valid"}, 128'(block_valid), 128'(1));
    check_eq({name, "_key"}, key_out, pack_half(0));
    check_eq({name, "_pt"}, plaintext_out, pack_half(16));
    check_eq({name, "_idle"}, 128'(busy), 128'(0));
    $display("frame %s key=%h pt=%h", name, key_out, plaintext_out);
  endtask

  task automatic release_frame(input string name);
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    check_eq({name, "_release"}, 128'(block_valid), 128'(0));
    block_ready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen_valid;
    bit  busy_ok;
    logic [127:0] exp_key, exp_pt;

    // Reset state
    idle(3);
    check_eq("rst_key", key_out, 128'h0);
    check_eq("rst_pt", plaintext_out, 128'h0);
    check_eq("rst_flags", {busy, block_valid, timeout_err, overflow_err}, 128'h0);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame, 100-cycle spacing, ready held high
    for (int i = 0; i < 32; i++) fb[i] = 8'(i);
    block_ready = 1'b1;
    send_frame("nominal", 0, 99, 99);
    check_eq("nominal_key_lit", key_out, 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("nominal_pt_lit", plaintext_out, 128'h101112131415161718191A1B1C1D1E1F);
    @(negedge clk);
    check_eq("nominal_onecycle", 128'(block_valid), 128'(0));
    block_ready = 1'b0;

    // Backpressure: hold 500 cycles, then an extra byte is dropped
    send_frame("bp", 0, 0, 20);
    exp_key = pack_half(0);
    exp_pt  = pack_half(16);
    busy_ok = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (block_valid !== 1'b1 || key_out !== exp_key || plaintext_out !== exp_pt) busy_ok = 1'b0;
    end
    check_eq("bp_stable", 128'(busy_ok), 128'(1));
    send_byte(8'hAA);
    check_eq("bp_overflow", 128'(overflow_err), 128'(1));
    check_eq("bp_key_kept", key_out, exp_key);
    check_eq("bp_pt_kept", plaintext_out, exp_pt);
    check_eq("bp_valid_kept", 128'(block_valid), 128'(1));
    @(negedge clk);
    check_eq("bp_overflow_pulse", 128'(overflow_err), 128'(0));
    release_frame("bp");

    // Random frames with random backpressure and stray bytes
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
      send_frame("rand", 0, 0, 12);
      exp_key = pack_half(0);
      n = int'($urandom_range(40, 1));
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(9, 0) == 0) begin
          send_byte(8'($urandom));
          check_eq("rand_overflow", 128'(overflow_err), 128'(1));
          check_eq("rand_key_kept", key_out, exp_key);
        end else begin
          @(negedge clk);
          check_eq("rand_hold", 128'({block_valid, overflow_err}), 128'(2'b10));
        end
      end
      release_frame("rand");
    end

    // Gap timeout after 5 bytes
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom));
      if (i < 4) idle(3);
    end
    n = 0;
    seen_valid = 1'b0;
    busy_ok = 1'b1;
    for (int c = 1; c <= TIMEOUT_CLKS + 200; c++) begin
      @(negedge clk);
      if (block_valid) seen_valid = 1'b1;
      if (timeout_err) begin
        n = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check_eq("to_cycle", 128'(n), 128'(TIMEOUT_CLKS));
    check_eq("to_busy_before", 128'(busy_ok), 128'(1));
    check_eq("to_busy_after", 128'(busy), 128'(0));
    check_eq("to_novalid", 128'(seen_valid), 128'(0));
    @(negedge clk);
    check_eq("to_pulse", 128'(timeout_err), 128'(0));
    $display("timeout after %0d cycles", n);
    for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
    send_frame("after_to", 0, 0, 10);

    // Same-cycle handshake and new first byte
    idle(10);
    @(negedge clk);
    block_ready  = 1'b1;
    data_in      = 8'h5A;
    data_in_done = 1'b1;
    @(negedge clk);
    data_in_done = 1'b0;
    block_ready  = 1'b0;
    check_eq("hs_valid", 128'(block_valid), 128'(0));
    check_eq("hs_overflow", 128'(overflow_err), 128'(0));
    check_eq("hs_busy", 128'(busy), 128'(1));
    fb[0] = 8'h5A;
    for (int i = 1; i < 32; i++) fb[i] = 8'($urandom);
    send_frame("hs", 1, 0, 8);
    check_eq("hs_first_byte", 128'(key_out[127:120]), 128'(8'h5A));
    release_frame("hs");

    // Asynchronous reset mid-frame
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_key", key_out, 128'h0);
    check_eq("arst_pt", plaintext_out, 128'h0);
    check_eq("arst_flags", {busy, block_valid, timeout_err, overflow_err}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
    block_ready = 1'b1;
    send_frame("after_rst", 0, 0, 10);
    @(negedge clk);
    check_eq("after_rst_release", 128'(block_valid), 128'(0));

    // Alternating 0x55/0xA3 pattern
    for (int i = 0; i < 32; i++) fb[i] = (i % 2 == 0) ? 8'h55 : 8'hA3;
    send_frame("pattern", 0, 20, 40);
    check_eq("pattern_key_lit", key_out, {8{16'h55A3}});
    check_eq("pattern_pt_lit", plaintext_out, {8{16'h55A3}});
    seen_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (block_valid) seen_valid = 1'b1;
    end
    check_eq("pattern_once", 128'(seen_valid), 128'(0));
    block_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
